// File: rtl/bcd_display_multi.sv
// bcd_display_multi
//   Multi-digit binary-to-7-segment display driver for active-low HEX
//   displays. A binary value is captured on an accepted load request and
//   converted to BCD with a sequential double-dabble engine (one shift per
//   clock). The display image is then registered in a single update cycle.
//
// Parameters
//   DIGITS : number of 7-segment digits driven (1..6)
//   BIN_W  : width of the binary input value (1..20)
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high reset (highest priority)
//   valor    in   [BIN_W]     unsigned value, sampled when a load is accepted
//   carregar in   load request, accepted only while idle
//   ocupado  out  high while a conversion is in flight (state != OCIOSO)
//   pronto   out  one-cycle pulse when saida has just been updated
//   saida    out  [7*DIGITS]  digit k at [7k+6:7k], bit0=a .. bit6=g, 0 = lit
//
// Build option
//   BCD_DISPLAY_LZ_BLANK_EN : when defined, leading zeros on digits 1..DIGITS-1
//   are blanked and the reset image is a single "0". When undefined, every
//   digit is shown zero-padded and the reset image is "0" on every digit.
//
// States
//   OCIOSO   | idle, waiting for carregar
//   CONVERTE | double-dabble shifting, BIN_W cycles
//   ATUALIZA | register new display image, pulse pronto
module bcd_display_multi #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      valor,
  input  logic                  carregar,
  output logic                  ocupado,
  output logic                  pronto,
  output logic [7*DIGITS-1:0]   saida
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam longint unsigned LIMIT    = pow10(DIGITS);
  localparam longint unsigned BIN_SPAN = 64'd1 << BIN_W;
  // When every representable input fits in DIGITS decimal digits the
  // overflow compare is removed entirely.
  localparam bit OVF_POSSIBLE = (BIN_SPAN > LIMIT);

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [7*DIGITS-1:0] reset_image();
    logic [7*DIGITS-1:0] img;
`ifdef BCD_DISPLAY_LZ_BLANK_EN
    img = {(7*DIGITS){1'b1}};
    img[6:0] = SEG_ZERO;
`else
    img = {DIGITS{SEG_ZERO}};
`endif
    return img;
  endfunction

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                ocupado_q, ocupado_d;
  logic                pronto_q, pronto_d;
  logic [7*DIGITS-1:0] saida_q, saida_d;
  logic [7*DIGITS-1:0] disp;
  logic                seen_nz;

  // Display image from the finished BCD accumulator. Digits are walked from
  // the most significant one down so seen_nz marks "a non-zero digit exists
  // at or above this position".
  always_comb begin
    disp    = '0;
    seen_nz = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end
      if (ovf_q) begin
        disp[7*k +: 7] = SEG_DASH;
      end else begin
`ifdef BCD_DISPLAY_LZ_BLANK_EN
        if (k != 0 && !seen_nz) begin
          disp[7*k +: 7] = SEG_BLANK;
        end else begin
          disp[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
        end
`else
        disp[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
`endif
      end
    end
  end

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    ocupado_d = ocupado_q;
    pronto_d  = 1'b0;
    saida_d   = saida_q;
    case (state_q)
      OCIOSO: begin
        if (carregar) begin
          bin_d     = valor;
          bcd_d     = '0;
          cnt_d     = CNT_W'(BIN_W);
          ovf_d     = OVF_POSSIBLE && (64'(valor) >= LIMIT);
          ocupado_d = 1'b1;
          state_d   = CONVERTE;
        end
      end
      CONVERTE: begin
        // Top bit of the adjusted accumulator falls off: excess beyond
        // DIGITS nibbles is discarded, the ovf flag covers that case.
        {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ATUALIZA;
        end
      end
      ATUALIZA: begin
        saida_d   = disp;
        pronto_d  = 1'b1;
        ocupado_d = 1'b0;
        state_d   = OCIOSO;
      end
      default: begin
        ocupado_d = 1'b0;
        state_d   = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= OCIOSO;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      saida_q   <= reset_image();
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
      saida_q   <= saida_d;
    end
  end

  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;
  assign saida   = saida_q;

endmodule

// File: doc/bcd_display_multi.md
Name: bcd_display_multi

Overview:
- Parametrised multi-digit successor to the single-digit BCD-to-7-segment decoder.
- Accepts a binary score or counter value and converts it to BCD with a sequential double-dabble engine, one shift per clock.
- Drives DIGITS active-low DE1-SoC HEX displays, with leading-zero blanking and an overflow indication.
- Sits between game/score logic and the HEX pins.

Parameters:
- DIGITS, 4: number of 7-segment digits driven (1..6).
- BIN_W, 14: width of the binary input value (1..20).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- valor  input  BIN_W  unsigned binary value to display; sampled on an accepted carregar
- carregar  input  1  load request; accepted only in OCIOSO
- ocupado  output  1  high while a conversion is in progress (state != OCIOSO)
- pronto  output  1  one-cycle pulse when saida has been updated
- saida  output  7*DIGITS  segments; digit k at bits [7k+6:7k]; bit0=a … bit6=g; 0 = lit

Behaviour:
- Segment codes (active-low, g..a):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001
  - 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0011000
  - blank 1111111, dash 0111111
- All outputs are registered.
- Reset, synchronous, highest priority:
  - state=OCIOSO; ocupado=0; pronto=0.
  - saida shows a single "0" on digit 0; digits 1..DIGITS-1 blank.
  - Any in-flight conversion is discarded; saida is not updated by it.
- FSM OCIOSO:
  - If carregar=1 at edge N: capture valor into shift register, clear BCD accumulator (4*DIGITS bits), set iteration counter=BIN_W.
  - Set ovf flag = (valor >= 10^DIGITS); go to CONVERTE.
  - ocupado=1 from cycle N+1.
- FSM CONVERTE:
  - Per cycle: for each BCD nibble, add 3 if nibble >= 5; then shift {bcd, bin} left by 1; decrement counter.
  - When the counter reaches 0 after BIN_W shifts, go to ATUALIZA.
  - If the accumulator would overflow DIGITS nibbles, excess bits are discarded; the ovf flag governs the display.
- FSM ATUALIZA:
  - Register the new saida; pulse pronto=1 for exactly one cycle; go to OCIOSO.
  - New saida and pronto are visible together at cycle N+BIN_W+2.
  - ocupado falls in that same cycle.
- Latency: carregar at edge N → saida/pronto valid at N+BIN_W+2. Throughput is one conversion per BIN_W+2 cycles.
- carregar while ocupado=1 is ignored: no queueing, and valor changes are not tracked.
- carregar held high continuously restarts a conversion on every return to OCIOSO.
- Overflow (ovf=1): all DIGITS show dash, regardless of the blanking option.
- saida holds its last value indefinitely between conversions.
- BIN_W small enough that 2^BIN_W <= 10^DIGITS: ovf is never set; the comparison is constant-folded.

Optional Feature:
- Macro: BCD_DISPLAY_LZ_BLANK_EN.
- Defined:
  - A digit k>0 shows blank if it and all more-significant digits are 0.
  - Digit 0 always shows its value, so value 0 displays "0".
  - Reset image: digit 0 "0", others blank.
- Undefined:
  - All digits always show their decimal value, zero-padded.
  - Reset image shows "0" on every digit.
- Overflow dash display is identical in both builds.

Test Plan (DIGITS=4, BIN_W=14, LZ_BLANK_EN defined unless noted):
- reset for 2 cycles → saida = {1111111,1111111,1111111,1000000}; ocupado=0, pronto=0.
- valor=1234, carregar pulse at edge N → ocupado=1 on N+1..N+15; pronto=1 only at N+16; saida = {1111001,0100100,0110000,0011001}.
- valor=57 → saida = {1111111,1111111,0010010,1111000}.
  - Without the macro: saida = {1000000,1000000,0010010,1111000}.
- valor=10000 → saida = four 0111111; valor=9999 → four 0011000.
- Start 1234, pulse carregar with valor=42 at N+5 → second request ignored; single pronto; display reads 1234.
- Start 9999, assert reset at N+7 → no pronto; saida returns to the reset image; the next carregar with valor=0 shows {1111111,1111111,1111111,1000000}.
